// File: rtl/cache_l2_assoc_if.sv
// Request/response and main-memory handshake bundle for cache_l2_assoc.
// slave is the cache side; master is the L1 requester together with the memory.
interface cache_l2_assoc_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_hit, resp_rdata,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_hit, resp_rdata,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/cache_l2_assoc.sv
// N-way set-associative write-back L2: true-LRU, write-allocate, explicit miss FSM.
// Optional macro CACHE_L2_STATS_EN adds saturating hit/miss/write-back counters.
module cache_l2_assoc #(
    parameter int WAYS   = 2,
    parameter int SETS   = 4,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 3
) (
    input  logic            clock,
    input  logic            resetn,
    cache_l2_assoc_if.slave bus
`ifdef CACHE_L2_STATS_EN
    ,
    output logic [15:0]     stat_hits,
    output logic [15:0]     stat_misses,
    output logic [15:0]     stat_wbacks
`endif
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int WAY_W  = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL_REQ, FILL_WAIT, RESP} state_t;
    state_t state;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

    logic              req_write_p0;
    logic [ADDR_W-1:0] req_addr_p0;
    logic [DATA_W-1:0] req_wdata_p0;
    logic [WAY_W-1:0]  vict_p1;

    logic              req_ready_q, resp_valid_q, resp_hit_q;
    logic              mem_req_valid_q, mem_req_write_q;
    logic [DATA_W-1:0] resp_rdata_q, mem_req_wdata_q;
    logic [ADDR_W-1:0] mem_req_addr_q;

    logic [IDX_W-1:0]  set_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit, inv_any, accept, fill_done, lru_upd;
    logic [WAY_W-1:0]  hit_way, inv_way, lru_way, vict_way, acc_way;
    logic [DATA_W-1:0] fill_data;

`ifdef CACHE_L2_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    assign set_idx   = req_addr_p0[IDX_W-1:0];
    assign req_tag   = req_addr_p0[ADDR_W-1:IDX_W];
    assign accept    = bus.req_valid && req_ready_q;
    assign fill_data = req_write_p0 ? req_wdata_p0 : bus.mem_resp_rdata;
    // A fill response arriving with the request handshake is taken immediately.
    assign fill_done = (state == FILL_REQ && bus.mem_req_ready && bus.mem_resp_valid) ||
                       (state == FILL_WAIT && bus.mem_resp_valid);
    assign lru_upd   = (state == LOOKUP && hit) || fill_done;
    assign acc_way   = (state == LOOKUP) ? hit_way : vict_p1;

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_write = mem_req_write_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.mem_req_wdata = mem_req_wdata_q;

    // Descending scan so the lowest matching / invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
        vict_way = inv_any ? inv_way : lru_way;
    end

    // p0: captured request; line payload storage (no reset, qualified by valid bits)
    always_ff @(posedge clock) begin
        if (accept) begin
            req_write_p0 <= bus.req_write;
            req_addr_p0  <= bus.req_addr;
            req_wdata_p0 <= bus.req_wdata;
        end
        if (state == LOOKUP && hit && req_write_p0) data_q[set_idx][hit_way] <= req_wdata_p0;
        if (fill_done) begin
            tag_q[set_idx][vict_p1]  <= req_tag;
            data_q[set_idx][vict_p1] <= fill_data;
        end
    end

    // p1: lookup / miss FSM, line state and LRU ages
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            vict_p1         <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
`ifdef CACHE_L2_STATS_EN
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbacks <= '0;
`endif
        end else begin
            if (lru_upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == acc_way)
                        age_q[set_idx][w] <= '0;
                    else if (age_q[set_idx][w] < age_q[set_idx][acc_way])
                        age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= LOOKUP;
                        req_ready_q <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_rdata_q <= req_write_p0 ? req_wdata_p0 : data_q[set_idx][hit_way];
                        if (req_write_p0) dirty_q[set_idx][hit_way] <= 1'b1;
`ifdef CACHE_L2_STATS_EN
                        stat_hits <= sat_inc(stat_hits);
`endif
                    end else begin
                        vict_p1         <= vict_way;
                        mem_req_valid_q <= 1'b1;
                        if (valid_q[set_idx][vict_way] && dirty_q[set_idx][vict_way]) begin
                            state           <= EVICT;
                            mem_req_write_q <= 1'b1;
                            mem_req_addr_q  <= {tag_q[set_idx][vict_way], set_idx};
                            mem_req_wdata_q <= data_q[set_idx][vict_way];
                        end else begin
                            state           <= FILL_REQ;
                            mem_req_write_q <= 1'b0;
                            mem_req_addr_q  <= req_addr_p0;
                            mem_req_wdata_q <= '0;
                        end
`ifdef CACHE_L2_STATS_EN
                        stat_misses <= sat_inc(stat_misses);
`endif
                    end
                end
                EVICT: begin
                    if (bus.mem_req_ready) begin
                        state           <= FILL_REQ;
                        mem_req_write_q <= 1'b0;
                        mem_req_addr_q  <= req_addr_p0;
                        mem_req_wdata_q <= '0;
`ifdef CACHE_L2_STATS_EN
                        stat_wbacks <= sat_inc(stat_wbacks);
`endif
                    end
                end
                FILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        if (!bus.mem_resp_valid) state <= FILL_WAIT;
                    end
                end
                FILL_WAIT: ;
                RESP: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_hit_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    req_ready_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (fill_done) begin
                state                     <= RESP;
                resp_valid_q              <= 1'b1;
                resp_hit_q                <= 1'b0;
                resp_rdata_q              <= fill_data;
                valid_q[set_idx][vict_p1] <= 1'b1;
                dirty_q[set_idx][vict_p1] <= req_write_p0;
            end
        end
    end
endmodule

// File: tb/tb_cache_l2_assoc.sv
// Randomized bench for cache_l2_assoc: a recency-ordered tag list per set plus an architectural
// memory image predict every response and every memory transaction.
module tb_cache_l2_assoc;
    localparam int WAYS = 2, SETS = 4, TAG_W = 8, DATA_W = 3;
    localparam int IDX_W = 2, ADDR_W = 10;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    cache_l2_assoc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef CACHE_L2_STATS_EN
    logic [15:0] stat_hits, stat_misses, stat_wbacks;
`endif

    cache_l2_assoc #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
`ifdef CACHE_L2_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
        .stat_wbacks (stat_wbacks)
`endif
    );

    typedef struct packed { logic [TAG_W-1:0] tag; logic dirty; } line_t;
    typedef struct packed { logic hit; logic [DATA_W-1:0] rdata; logic [31:0] acc; } resp_t;
    typedef struct packed { logic wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } mreq_t;

    line_t             lines [SETS][$];          // index 0 = most recently used
    logic [DATA_W-1:0] golden  [1 << ADDR_W];    // value a read must return
    logic [DATA_W-1:0] backmem [1 << ADDR_W];    // what the memory really holds
    resp_t             exp_resp_q [$];
    mreq_t             exp_mem_q [$];

    int vectors = 0, miscompares = 0, cyc = 0;
    int m_hits = 0, m_misses = 0, m_wbacks = 0;
    bit no_fill = 1'b0, hold_evict = 1'b0, fill_pend = 1'b0;
    int fill_cnt = 0, hold_cnt = 0;
    logic [ADDR_W-1:0] fill_addr, last_wb_addr, last_fill_addr;
    logic [DATA_W-1:0] last_wb_data, last_rdata, rsp_data;
    logic              last_hit, rdy, rsp;
    resp_t             cur_r;
    mreq_t             cur_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic summary_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out, got no progress expected completion (cycle %0d)", name, cyc);
        summary_and_finish();
    endtask

    task automatic model_access(input bit wr, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] wd, input int acc);
        int s, idx;
        logic [TAG_W-1:0] t;
        line_t ln, v;
        resp_t r;
        mreq_t m;
        s = int'(a[IDX_W-1:0]);
        t = a[ADDR_W-1:IDX_W];
        idx = -1;
        for (int i = 0; i < lines[s].size(); i++)
            if (idx < 0 && lines[s][i].tag == t) idx = i;
        if (idx >= 0) begin
            r.hit = 1'b1;
            ln = lines[s][idx];
            lines[s].delete(idx);
            ln.dirty = ln.dirty | wr;
            m_hits++;
        end else begin
            r.hit = 1'b0;
            m_misses++;
            if (lines[s].size() == WAYS) begin
                v = lines[s].pop_back();
                if (v.dirty) begin
                    m.wr = 1'b1;
                    m.addr = {v.tag, a[IDX_W-1:0]};
                    m.wdata = golden[{v.tag, a[IDX_W-1:0]}];
                    exp_mem_q.push_back(m);
                    m_wbacks++;
                end
            end
            m.wr = 1'b0;
            m.addr = a;
            m.wdata = '0;
            exp_mem_q.push_back(m);
            ln.tag = t;
            ln.dirty = wr;
        end
        lines[s].push_front(ln);
        if (wr) golden[a] = wd;
        r.rdata = golden[a];
        r.acc = 32'(acc);
        exp_resp_q.push_back(r);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Compare process plus memory responder; outputs sampled on the falling edge.
    always @(negedge clock) begin
        if (!resetn) begin
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_rdata = '0;
            fill_pend = 1'b0;
        end else begin
            if (bus.resp_valid) begin
                chk("resp_req_ready_low", 32'(bus.req_ready), 32'(0));
                chk("resp_expected", 32'(exp_resp_q.size() != 0), 32'(1));
                if (exp_resp_q.size() != 0) begin
                    cur_r = exp_resp_q.pop_front();
                    chk("resp_hit", 32'(bus.resp_hit), 32'(cur_r.hit));
                    chk("resp_rdata", 32'(bus.resp_rdata), 32'(cur_r.rdata));
                    if (cur_r.hit) chk("hit_latency", 32'(cyc) - cur_r.acc, 32'(2));
                end
                last_hit = bus.resp_hit;
                last_rdata = bus.resp_rdata;
            end
            if (bus.mem_req_valid) begin
                chk("memreq_req_ready_low", 32'(bus.req_ready), 32'(0));
                chk("memreq_expected", 32'(exp_mem_q.size() != 0), 32'(1));
                if (exp_mem_q.size() != 0) begin
                    cur_m = exp_mem_q[0];
                    chk("memreq_write", 32'(bus.mem_req_write), 32'(cur_m.wr));
                    chk("memreq_addr", 32'(bus.mem_req_addr), 32'(cur_m.addr));
                    if (cur_m.wr) chk("memreq_wdata", 32'(bus.mem_req_wdata), 32'(cur_m.wdata));
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (hold_evict && bus.mem_req_valid && bus.mem_req_write && hold_cnt < 5) begin
                rdy = 1'b0;
                hold_cnt++;
            end
            rsp = 1'b0;
            rsp_data = DATA_W'($urandom);
            if (bus.mem_req_valid && rdy) begin
                if (bus.mem_req_write) begin
                    backmem[bus.mem_req_addr] = bus.mem_req_wdata;
                    last_wb_addr = bus.mem_req_addr;
                    last_wb_data = bus.mem_req_wdata;
                end else begin
                    fill_addr = bus.mem_req_addr;
                    last_fill_addr = bus.mem_req_addr;
                    if (!no_fill && $urandom_range(0, 2) == 0) begin
                        rsp = 1'b1;
                        rsp_data = backmem[bus.mem_req_addr];
                    end else begin
                        fill_pend = 1'b1;
                        fill_cnt = $urandom_range(0, 3);
                    end
                end
                if (exp_mem_q.size() != 0) void'(exp_mem_q.pop_front());
            end else if (fill_pend) begin
                if (!no_fill) begin
                    if (fill_cnt == 0) begin
                        rsp = 1'b1;
                        rsp_data = backmem[fill_addr];
                        fill_pend = 1'b0;
                    end else begin
                        fill_cnt--;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                rsp = 1'b1;   // stray response the cache must ignore
            end
            bus.mem_req_ready  = rdy;
            bus.mem_resp_valid = rsp;
            bus.mem_resp_rdata = rsp_data;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'(1));
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
        chk("rst_resp_hit", 32'(bus.resp_hit), 32'(0));
        chk("rst_resp_rdata", 32'(bus.resp_rdata), 32'(0));
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'(0));
        chk("rst_mem_req_write", 32'(bus.mem_req_write), 32'(0));
        chk("rst_mem_req_addr", 32'(bus.mem_req_addr), 32'(0));
        chk("rst_mem_req_wdata", 32'(bus.mem_req_wdata), 32'(0));
        repeat (2) @(negedge clock);
        for (int s = 0; s < SETS; s++) lines[s].delete();
        golden = backmem;
        exp_resp_q.delete();
        exp_mem_q.delete();
        m_hits = 0;
        m_misses = 0;
        m_wbacks = 0;
        resetn = 1'b1;
    endtask

    task automatic do_req(input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input bit wait_done);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.req_ready) begin
            n++;
            if (n > 200) timeout("req_ready_wait");
            @(negedge clock);
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        model_access(wr, a, wd, cyc);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_wdata = DATA_W'($urandom);
        if (wait_done) begin
            n = 0;
            while (exp_resp_q.size() != 0 || exp_mem_q.size() != 0) begin
                n++;
                if (n > 300) timeout("resp_wait");
                @(negedge clock);
            end
        end
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) backmem[i] = DATA_W'($urandom);
        backmem[10'h0C5] = 3'b101;
        do_reset();

        do_req(1'b0, 10'h0C5, 3'd0, 1'b1);
        chk("t1_fill_addr", 32'(last_fill_addr), 32'h0C5);
        chk("t1_hit", 32'(last_hit), 32'(0));
        chk("t1_rdata", 32'(last_rdata), 32'(5));

        do_req(1'b0, 10'h0C5, 3'd0, 1'b1);
        chk("t2_hit", 32'(last_hit), 32'(1));
        chk("t2_rdata", 32'(last_rdata), 32'(5));

        do_req(1'b1, 10'h0C5, 3'b010, 1'b1);
        chk("t3_write_hit", 32'(last_hit), 32'(1));
        chk("t3_write_rdata", 32'(last_rdata), 32'(2));
        do_req(1'b0, 10'h0D5, 3'd0, 1'b1);
        chk("t3_0d5_fill_addr", 32'(last_fill_addr), 32'h0D5);
        hold_evict = 1'b1;
        do_req(1'b0, 10'h0E5, 3'd0, 1'b1);
        hold_evict = 1'b0;
        chk("t3_wb_addr", 32'(last_wb_addr), 32'h0C5);
        chk("t3_wb_data", 32'(last_wb_data), 32'(2));
        chk("t3_fill_addr", 32'(last_fill_addr), 32'h0E5);
        chk("t4_evict_hold_cycles", 32'(hold_cnt), 32'(5));

        no_fill = 1'b1;
        do_req(1'b0, 10'h1C5, 3'd0, 1'b0);
        n = 0;
        while (exp_mem_q.size() != 0) begin
            n++;
            if (n > 100) timeout("t5_fill_handshake");
            @(negedge clock);
        end
        repeat (3) @(negedge clock);
        chk("t5_no_resp_while_waiting", 32'(bus.resp_valid), 32'(0));
        do_reset();
        no_fill = 1'b0;
        do_req(1'b0, 10'h0C5, 3'd0, 1'b1);
        chk("t5_post_reset_hit", 32'(last_hit), 32'(0));
        chk("t5_post_reset_rdata", 32'(last_rdata), 32'(2));

        for (int i = 0; i < 500; i++)
            do_req(1'($urandom_range(0, 1)),
                   {TAG_W'($urandom_range(0, 5)), IDX_W'($urandom_range(0, SETS - 1))},
                   DATA_W'($urandom), 1'b1);

`ifdef CACHE_L2_STATS_EN
        chk("stat_hits", 32'(stat_hits), 32'(m_hits));
        chk("stat_misses", 32'(stat_misses), 32'(m_misses));
        chk("stat_wbacks", 32'(stat_wbacks), 32'(m_wbacks));
`endif
        chk("end_resp_queue", 32'(exp_resp_q.size()), 32'(0));
        chk("end_mem_queue", 32'(exp_mem_q.size()), 32'(0));
        summary_and_finish();
    end
endmodule
